// File: rtl/switch_allocator_if.sv
// Switch allocator port bundle: request/handshake inputs from the input ports and
// the path controls (mux select, busy, reserved, error) driven to the mux switch.
interface switch_allocator_if #(
    parameter int INPUTS        = 4,
    parameter int OUTPUTS       = 4,
    parameter int REQUEST_WIDTH = 32
);
    logic [INPUTS-1:0]                request_valid;
    logic [INPUTS*REQUEST_WIDTH-1:0]  request_dest;
    logic [INPUTS-1:0]                tail_in;
    logic [INPUTS-1:0]                valid_in;
    logic [INPUTS-1:0]                ready_in;
    logic [OUTPUTS*REQUEST_WIDTH-1:0] routeSelect;
    logic [INPUTS*REQUEST_WIDTH-1:0]  inputRoute;
    logic [OUTPUTS-1:0]               outputBusy;
    logic [INPUTS-1:0]                PortReserved;
    logic                             request_error;

    modport master (
        output request_valid, request_dest, tail_in, valid_in, ready_in,
        input  routeSelect, inputRoute, outputBusy, PortReserved, request_error
    );

    modport slave (
        input  request_valid, request_dest, tail_in, valid_in, ready_in,
        output routeSelect, inputRoute, outputBusy, PortReserved, request_error
    );
endinterface

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator; 1-cycle grant, path held until tail handshake (stalls hold it).
// Define SWITCH_ALLOC_FAST_REGRANT_EN to re-arbitrate an output on its release edge (no idle bubble).
module switch_allocator #(
    parameter int INPUTS        = 4,
    parameter int OUTPUTS       = 4,
    parameter int REQUEST_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    switch_allocator_if.slave sw
);
    localparam int PTR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                   r_state     [OUTPUTS];
    logic [PTR_W-1:0]         r_ptr       [OUTPUTS];
    logic [REQUEST_WIDTH-1:0] r_route_sel [OUTPUTS];
    logic [REQUEST_WIDTH-1:0] r_in_route  [INPUTS];
    logic [INPUTS-1:0]        r_reserved;
    logic                     r_err;

    state_t                   w_state_nxt [OUTPUTS];
    logic [INPUTS-1:0]        w_cand      [OUTPUTS];
    logic [PTR_W-1:0]         w_winner    [OUTPUTS];
    logic [PTR_W-1:0]         w_owner     [OUTPUTS];
    logic [OUTPUTS-1:0]       w_grant;
    logic [OUTPUTS-1:0]       w_release;
    logic [INPUTS-1:0]        w_hs_tail;
    logic [INPUTS-1:0]        w_bad;
    logic                     w_arb_en;
    logic [PTR_W-1:0]         w_idx;

    // Reserved inputs never compete, which keeps each input on at most one output.
    always_comb begin
        w_hs_tail = sw.valid_in & sw.ready_in & sw.tail_in;
        for (int i = 0; i < INPUTS; i++) begin
            w_bad[i] = sw.request_valid[i] && !r_reserved[i] &&
                       (sw.request_dest[i*REQUEST_WIDTH +: REQUEST_WIDTH] >= REQUEST_WIDTH'(OUTPUTS));
        end
        for (int j = 0; j < OUTPUTS; j++) begin
            for (int i = 0; i < INPUTS; i++) begin
                w_cand[j][i] = sw.request_valid[i] && !r_reserved[i] &&
                               (sw.request_dest[i*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(j));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < OUTPUTS; j++) r_state[j] <= IDLE;
        end else begin
            for (int j = 0; j < OUTPUTS; j++) r_state[j] <= w_state_nxt[j];
        end
    end

    always_comb begin
        w_arb_en = 1'b0;
        w_idx    = '0;
        for (int j = 0; j < OUTPUTS; j++) begin
            w_state_nxt[j] = r_state[j];
            w_grant[j]     = 1'b0;
            w_winner[j]    = '0;
            w_owner[j]     = r_route_sel[j][PTR_W-1:0];
            w_release[j]   = (r_state[j] == BUSY) && w_hs_tail[w_owner[j]];
`ifdef SWITCH_ALLOC_FAST_REGRANT_EN
            w_arb_en = (r_state[j] == IDLE) || w_release[j];
`else
            w_arb_en = (r_state[j] == IDLE);
`endif
            // Search upward from the pointer with wrap; first candidate wins.
            for (int k = 0; k < INPUTS; k++) begin
                w_idx = PTR_W'((int'(r_ptr[j]) + k) % INPUTS);
                if (w_arb_en && !w_grant[j] && w_cand[j][w_idx]) begin
                    w_grant[j]  = 1'b1;
                    w_winner[j] = w_idx;
                end
            end
            if (w_grant[j]) begin
                w_state_nxt[j] = BUSY;
            end else if (w_release[j]) begin
                w_state_nxt[j] = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < OUTPUTS; j++) begin
                r_ptr[j]       <= '0;
                r_route_sel[j] <= '0;
            end
            for (int i = 0; i < INPUTS; i++) r_in_route[i] <= '0;
            r_reserved <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= r_err | (|w_bad);
            for (int j = 0; j < OUTPUTS; j++) begin
                if (w_release[j]) r_reserved[w_owner[j]] <= 1'b0;
            end
            // Route fields are left stale on release; consumers qualify them with busy/reserved.
            for (int j = 0; j < OUTPUTS; j++) begin
                if (w_grant[j]) begin
                    r_route_sel[j]          <= REQUEST_WIDTH'(w_winner[j]);
                    r_in_route[w_winner[j]] <= REQUEST_WIDTH'(j);
                    r_reserved[w_winner[j]] <= 1'b1;
                    r_ptr[j]                <= (w_winner[j] == PTR_W'(INPUTS-1)) ? '0
                                                                                 : PTR_W'(w_winner[j] + 1'b1);
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < OUTPUTS; j++) begin
            sw.outputBusy[j]                                = (r_state[j] == BUSY);
            sw.routeSelect[j*REQUEST_WIDTH +: REQUEST_WIDTH] = r_route_sel[j];
        end
        for (int i = 0; i < INPUTS; i++) begin
            sw.inputRoute[i*REQUEST_WIDTH +: REQUEST_WIDTH] = r_in_route[i];
        end
        sw.PortReserved  = r_reserved;
        sw.request_error = r_err;
    end
endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: reset, round-robin contention, packet hold,
// parallel grants, bad destination, stalled tail and asynchronous reset mid-packet.
module tb_switch_allocator;
    localparam int RW = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    switch_allocator_if #(.INPUTS(4), .OUTPUTS(4), .REQUEST_WIDTH(RW)) sw_if ();

    switch_allocator #(.INPUTS(4), .OUTPUTS(4), .REQUEST_WIDTH(RW)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] rsel(input int j);
        return sw_if.routeSelect[j*RW +: RW];
    endfunction

    function automatic logic [RW-1:0] iroute(input int i);
        return sw_if.inputRoute[i*RW +: RW];
    endfunction

    task automatic set_req(input int i, input logic v, input logic [RW-1:0] d);
        sw_if.request_valid[i]      = v;
        sw_if.request_dest[i*RW +: RW] = d;
    endtask

    task automatic set_hs(input int i, input logic v, input logic r, input logic t);
        sw_if.valid_in[i] = v;
        sw_if.ready_in[i] = r;
        sw_if.tail_in[i]  = t;
    endtask

    task automatic clear_all();
        sw_if.request_valid = '0;
        sw_if.request_dest  = '0;
        sw_if.valid_in      = '0;
        sw_if.ready_in      = '0;
        sw_if.tail_in       = '0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

`ifdef SWITCH_ALLOC_FAST_REGRANT_EN
    localparam int NCONT = 4;
    logic        cont_busy [NCONT] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [RW-1:0] cont_sel [NCONT] = '{32'd0, 32'd1, 32'd3, 32'd0};
`else
    localparam int NCONT = 7;
    logic        cont_busy [NCONT] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [RW-1:0] cont_sel [NCONT] = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd3, 32'd0, 32'd0};
`endif

    initial begin
        rst = 1'b0;
        clear_all();
        tick();
        check("reset_busy",     64'(sw_if.outputBusy),    64'h0);
        check("reset_reserved", 64'(sw_if.PortReserved),  64'h0);
        check("reset_error",    64'(sw_if.request_error), 64'h0);
        rst = 1'b1;

        // Round-robin contention on output 2 with single-flit packets.
        for (int i = 0; i < 4; i++) begin
            if (i != 2) begin
                set_req(i, 1'b1, 32'd2);
                set_hs(i, 1'b1, 1'b1, 1'b1);
            end
        end
        for (int c = 0; c < NCONT; c++) begin
            tick();
            check($sformatf("rr_busy_%0d", c), 64'(sw_if.outputBusy[2]), 64'(cont_busy[c]));
            if (cont_busy[c]) check($sformatf("rr_sel_%0d", c), 64'(rsel(2)), 64'(cont_sel[c]));
        end
        sw_if.request_valid = '0;
        tick();
        check("rr_drain_busy", 64'(sw_if.outputBusy), 64'h0);
        clear_all();
        tick();

        // Multi-flit packet from input 1 to output 0 with a stall; input 2 waits.
        set_req(1, 1'b1, 32'd0);
        set_req(2, 1'b1, 32'd0);
        tick();
        check("mf_busy",     64'(sw_if.outputBusy),   64'h1);
        check("mf_sel",      64'(rsel(0)),            64'd1);
        check("mf_reserved", 64'(sw_if.PortReserved), 64'h2);
        check("mf_iroute1",  64'(iroute(1)),          64'd0);
        set_req(1, 1'b0, 32'd0);
        set_hs(1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        set_hs(1, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("mf_stall_sel_%0d", c), 64'(rsel(0)),            64'd1);
            check($sformatf("mf_stall_res_%0d", c), 64'(sw_if.PortReserved), 64'h2);
        end
        set_hs(1, 1'b1, 1'b1, 1'b0);
        tick();
        check("mf_pre_tail_busy", 64'(sw_if.outputBusy), 64'h1);
        set_hs(1, 1'b1, 1'b1, 1'b1);
        tick();
        check("mf_rel_res1", 64'(sw_if.PortReserved[1]), 64'h0);
`ifdef SWITCH_ALLOC_FAST_REGRANT_EN
        check("mf_rel_busy", 64'(sw_if.outputBusy), 64'h1);
        check("mf_rel_sel",  64'(rsel(0)),          64'd2);
`else
        check("mf_rel_busy", 64'(sw_if.outputBusy),   64'h0);
        check("mf_rel_res",  64'(sw_if.PortReserved), 64'h0);
`endif
        set_hs(1, 1'b0, 1'b0, 1'b0);
        tick();
        check("mf_next_busy", 64'(sw_if.outputBusy),   64'h1);
        check("mf_next_sel",  64'(rsel(0)),            64'd2);
        check("mf_next_res",  64'(sw_if.PortReserved), 64'h4);
        set_req(2, 1'b0, 32'd0);
        set_hs(2, 1'b1, 1'b1, 1'b1);
        tick();
        clear_all();
        tick();
        check("mf_drain_busy", 64'(sw_if.outputBusy), 64'h0);

        // Four disjoint requests granted on the same edge.
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, RW'(3 - i));
        tick();
        check("par_busy",     64'(sw_if.outputBusy),   64'hF);
        check("par_reserved", 64'(sw_if.PortReserved), 64'hF);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("par_sel_%0d", k),    64'(rsel(k)),   64'(3 - k));
            check($sformatf("par_iroute_%0d", k), 64'(iroute(k)), 64'(3 - k));
        end
        sw_if.request_valid = '0;
        for (int i = 0; i < 4; i++) set_hs(i, 1'b1, 1'b1, 1'b1);
        tick();
        check("par_rel_busy", 64'(sw_if.outputBusy),   64'h0);
        check("par_rel_res",  64'(sw_if.PortReserved), 64'h0);
        check("par_rel_hold", 64'(rsel(2)),            64'd1);
        clear_all();
        tick();

        // Out-of-range destination.
        check("bad_pre_err", 64'(sw_if.request_error), 64'h0);
        set_req(3, 1'b1, 32'd7);
        tick();
        check("bad_busy", 64'(sw_if.outputBusy),    64'h0);
        check("bad_res",  64'(sw_if.PortReserved),  64'h0);
        check("bad_err",  64'(sw_if.request_error), 64'h1);
        set_req(3, 1'b0, 32'd0);
        tick();
        check("bad_err_sticky", 64'(sw_if.request_error), 64'h1);

        // Tail presented without ready keeps the path.
        set_req(0, 1'b1, 32'd1);
        tick();
        check("tail_grant_busy", 64'(sw_if.outputBusy), 64'h2);
        check("tail_iroute0",    64'(iroute(0)),        64'd1);
        set_req(0, 1'b0, 32'd0);
        set_hs(0, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("tail_stall_busy_%0d", c), 64'(sw_if.outputBusy),   64'h2);
            check($sformatf("tail_stall_res_%0d", c),  64'(sw_if.PortReserved), 64'h1);
        end
        set_hs(0, 1'b1, 1'b1, 1'b1);
        tick();
        check("tail_rel_busy", 64'(sw_if.outputBusy),   64'h0);
        check("tail_rel_res",  64'(sw_if.PortReserved), 64'h0);
        clear_all();
        tick();

        // Asynchronous reset while output 2 is mid-packet.
        set_req(1, 1'b1, 32'd2);
        tick();
        check("rst_pre_busy", 64'(sw_if.outputBusy), 64'h4);
        check("rst_pre_sel",  64'(rsel(2)),          64'd1);
        set_req(1, 1'b0, 32'd0);
        set_hs(1, 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_busy",   64'(sw_if.outputBusy),    64'h0);
        check("rst_async_res",    64'(sw_if.PortReserved),  64'h0);
        check("rst_async_err",    64'(sw_if.request_error), 64'h0);
        check("rst_async_sel2",   64'(rsel(2)),             64'd0);
        check("rst_async_iroute", 64'(iroute(1)),           64'd0);
        tick();
        rst = 1'b1;
        clear_all();
        set_req(0, 1'b1, 32'd1);
        tick();
        check("rst_after_busy",   64'(sw_if.outputBusy),   64'h2);
        check("rst_after_res",    64'(sw_if.PortReserved), 64'h1);
        check("rst_after_iroute", 64'(iroute(0)),          64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
